divider_arbiter: RTL and testbench
==================================

# divider_arbiter

Round-robin arbiter and sequencer that shares one iterative `divider` instance among several requesters, such as per-voice gain normalisation and the mixer output normaliser. It accepts operand pairs over valid/ready handshakes and issues exactly one division at a time to the shared divider. It captures the divider's result and routes it back to the requester that issued it as a one-cycle response pulse. It sits between the audio-path blocks that need division and the single `divider` in the top level.

## Interface
- `NUM_REQ`, default 4: number of requesters, minimum 2.
- `WIDTH`, default 32: operand and result width; must match the divider's `WIDTH`.
- `TIMEOUT_CYCLES`, default 64: watchdog limit in WAIT; only used with `DIV_ARB_TIMEOUT_EN`.
- `clk_in` input, 1 bit: single system clock.
- `rst_in` input, 1 bit: synchronous, active-high reset.
- `req_valid_in` input, NUM_REQ bits: per-requester request valid.
- `req_dividend_in` input, NUM_REQ*WIDTH bits: packed dividends; requester i occupies `[i*WIDTH +: WIDTH]`.
- `req_divisor_in` input, NUM_REQ*WIDTH bits: packed divisors, same packing as dividends.
- `req_ready_out` output, NUM_REQ bits: one-hot acceptance strobe (combinational).
- `resp_valid_out` output, NUM_REQ bits: one-hot, one-cycle result strobe to the issuing requester.
- `resp_quotient_out` output, WIDTH bits: result quotient; shared by all requesters.
- `resp_remainder_out` output, WIDTH bits: result remainder; shared by all requesters.
- `resp_error_out` output, 1 bit: divider error (divide-by-zero) or watchdog timeout.
- `div_dividend_out` output, WIDTH bits: operand to the divider, held stable from accept until the next accept.
- `div_divisor_out` output, WIDTH bits: operand to the divider, held stable from accept until the next accept.
- `div_data_valid_out` output, 1 bit: start strobe to the divider.
- `div_quotient_in` input, WIDTH bits: divider result.
- `div_remainder_in` input, WIDTH bits: divider result.
- `div_data_valid_in` input, 1 bit: divider result strobe.
- `div_error_in` input, 1 bit: divider error flag.
- `div_busy_in` input, 1 bit: divider busy flag.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESPOND.
- **IDLE**
  - Grant goes to the first requester with `req_valid_in` high, searching from `last_grant+1` modulo NUM_REQ.
  - `req_ready_out[g]` is high that cycle.
  - Operands and grant ID are latched, `last_grant` is set to g, and the FSM moves to ISSUE.
  - With no valid request, the FSM stays in IDLE.
- **ISSUE**
  - When `div_busy_in` is low, `div_data_valid_out` is high for exactly one cycle and the FSM moves to WAIT.
  - When `div_busy_in` is high, the FSM holds in ISSUE with the strobe low.
- **WAIT**
  - On `div_data_valid_in`, quotient, remainder and error are registered into the `resp_*` outputs and the FSM moves to RESPOND.
- **RESPOND**
  - `resp_valid_out` has the latched ID bit set for one cycle; the FSM then returns to IDLE.
  - No request is accepted in this cycle.
- `div_data_valid_in` arriving in IDLE, ISSUE or RESPOND is ignored.
- `req_ready_out` is zero outside IDLE.
- A requester may drop `req_valid_in` without penalty before it is granted. Once granted, the request is committed.
- `resp_quotient_out`, `resp_remainder_out` and `resp_error_out` hold their values until the next RESPOND.
- Divisor 0 is passed through to the divider unchanged; its error flag propagates to `resp_error_out`.
- Reset mid-operation:
  - The in-flight division is abandoned and no response is emitted.
  - The next `div_data_valid_in` is ignored unless the FSM is in WAIT.

## Timing
- Reset values:
  - All outputs are 0.
  - The FSM is in IDLE.
  - `last_grant` is NUM_REQ-1, so requester 0 wins first.
- Accept-to-response timing, for accept in cycle T, divider start strobe in T+1, and divider latency L (start strobe to result strobe):
  - Response data is registered at the end of T+1+L.
  - `resp_valid_out` is high in T+2+L.
  - The next accept is possible in T+3+L at the earliest.
- Issue is delayed by one cycle per cycle that `div_busy_in` is high in ISSUE.
- Fairness: any continuously-valid requester is granted within NUM_REQ grants.

## Configuration
- `DIV_ARB_TIMEOUT_EN` defined:
  - A counter runs in WAIT.
  - If `TIMEOUT_CYCLES` cycles elapse with no `div_data_valid_in`, the FSM moves to RESPOND with `resp_error_out`=1 and quotient and remainder 0.
  - A drop flag is set so that the next `div_data_valid_in` is discarded.
  - Reset clears the counter and the drop flag.
- `DIV_ARB_TIMEOUT_EN` undefined:
  - There is no counter; WAIT waits indefinitely.
  - `TIMEOUT_CYCLES` is unused.

## Test plan
- **Single request:** requester 2 issues 1000/7 with a model divider of L=33 → `req_ready_out`=4'b0100 at T, `resp_valid_out`=4'b0100 at T+35, quotient 142, remainder 6, error 0.
- **All four held valid from reset, with distinct operands:** → grant order 0,1,2,3,0, and each response is routed to its own issuer with correct results.
- **Divide by zero:** requester 1 issues 55/0 → `resp_error_out`=1 with `resp_valid_out`=4'b0010; the next request is serviced normally.
- **Busy stall:** `div_busy_in` held high for 5 cycles after an accept → start strobe in T+6, a single pulse, and the response shifted by 5 cycles.
- **Reset mid-operation:** `rst_in` pulsed in WAIT, followed by a late `div_data_valid_in` → no `resp_valid_out`, all outputs 0, and the next grant goes to requester 0.
- **Timeout (with `DIV_ARB_TIMEOUT_EN`):** the divider never responds → `resp_error_out`=1 exactly `TIMEOUT_CYCLES`+1 cycles after entering WAIT. A late strobe is then dropped, and the following request completes correctly.

Source files
------------

// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one iterative divider among NUM_REQ requesters.
// Optional watchdog in WAIT is enabled by defining DIV_ARB_TIMEOUT_EN.
module divider_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [NUM_REQ-1:0]       req_valid_in,
  input  logic [NUM_REQ*WIDTH-1:0] req_dividend_in,
  input  logic [NUM_REQ*WIDTH-1:0] req_divisor_in,
  output logic [NUM_REQ-1:0]       req_ready_out,
  output logic [NUM_REQ-1:0]       resp_valid_out,
  output logic [WIDTH-1:0]         resp_quotient_out,
  output logic [WIDTH-1:0]         resp_remainder_out,
  output logic                     resp_error_out,
  output logic [WIDTH-1:0]         div_dividend_out,
  output logic [WIDTH-1:0]         div_divisor_out,
  output logic                     div_data_valid_out,
  input  logic [WIDTH-1:0]         div_quotient_in,
  input  logic [WIDTH-1:0]         div_remainder_in,
  input  logic                     div_data_valid_in,
  input  logic                     div_error_in,
  input  logic                     div_busy_in
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_RESPOND = 2'd3;

  localparam logic [GW-1:0]      LAST_RST = GW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_BIT  = {{(NUM_REQ-1){1'b0}}, 1'b1};

  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("divider_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic [1:0]       state;
  logic [GW-1:0]    last_grant;
  logic [GW-1:0]    grant_id;
  logic [GW-1:0]    pick;
  logic [GW-1:0]    cand;
  logic             pick_found;
  logic [WIDTH-1:0] pick_dividend;
  logic [WIDTH-1:0] pick_divisor;
  logic             take;
  logic             timeout;

  // Rotating priority: search starts one past the previous winner.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    cand       = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = GW'((32'(last_grant) + i) % 32'(NUM_REQ));
      if (!pick_found && req_valid_in[cand]) begin
        pick_found = 1'b1;
        pick       = cand;
      end
    end
  end

  always_comb begin
    pick_dividend = '0;
    pick_divisor  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (GW'(i) == pick) begin
        pick_dividend = req_dividend_in[i*WIDTH +: WIDTH];
        pick_divisor  = req_divisor_in[i*WIDTH +: WIDTH];
      end
    end
  end

  assign req_ready_out      = (state == ST_IDLE && pick_found) ? (ONE_BIT << pick) : '0;
  assign resp_valid_out     = (state == ST_RESPOND) ? (ONE_BIT << grant_id) : '0;
  assign div_data_valid_out = (state == ST_ISSUE) && !div_busy_in;

`ifdef DIV_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wd_count;
  logic          drop;

  assign take    = (state == ST_WAIT) && div_data_valid_in && !drop;
  assign timeout = (state == ST_WAIT) && !take && (wd_count == TW'(TIMEOUT_CYCLES));

  // Counter saturates at the limit; drop swallows the abandoned division's late strobe.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wd_count <= '0;
      drop     <= 1'b0;
    end else begin
      if (state != ST_WAIT)
        wd_count <= '0;
      else if (wd_count != TW'(TIMEOUT_CYCLES))
        wd_count <= wd_count + 1'b1;
      if (timeout)
        drop <= 1'b1;
      else if (div_data_valid_in)
        drop <= 1'b0;
    end
  end
`else
  assign take    = (state == ST_WAIT) && div_data_valid_in;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state              <= ST_IDLE;
      last_grant         <= LAST_RST;
      grant_id           <= '0;
      div_dividend_out   <= '0;
      div_divisor_out    <= '0;
      resp_quotient_out  <= '0;
      resp_remainder_out <= '0;
      resp_error_out     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant_id         <= pick;
            last_grant       <= pick;
            div_dividend_out <= pick_dividend;
            div_divisor_out  <= pick_divisor;
            state            <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!div_busy_in)
            state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (take) begin
            resp_quotient_out  <= div_quotient_in;
            resp_remainder_out <= div_remainder_in;
            resp_error_out     <= div_error_in;
            state              <= ST_RESPOND;
          end else if (timeout) begin
            resp_quotient_out  <= '0;
            resp_remainder_out <= '0;
            resp_error_out     <= 1'b1;
            state              <= ST_RESPOND;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_arbiter.sv
// Randomised self-checking bench for divider_arbiter with a latency-programmable divider model.
// Timeout scenario runs only when DIV_ARB_TIMEOUT_EN is defined.
module tb_divider_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TC = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_dividend;
  logic [N*W-1:0] req_divisor;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_q;
  logic [W-1:0]   resp_r;
  logic           resp_err;
  logic [W-1:0]   div_a;
  logic [W-1:0]   div_b;
  logic           div_start;
  logic [W-1:0]   div_q   = '0;
  logic [W-1:0]   div_r   = '0;
  logic           div_dv  = 1'b0;
  logic           div_err = 1'b0;
  logic           div_busy;

  int errors = 0;
  int checks = 0;
  int lat = 4;
  int exp_last;

  divider_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(TC)) dut (
    .clk_in(clk), .rst_in(rst),
    .req_valid_in(req_valid), .req_dividend_in(req_dividend), .req_divisor_in(req_divisor),
    .req_ready_out(req_ready), .resp_valid_out(resp_valid),
    .resp_quotient_out(resp_q), .resp_remainder_out(resp_r), .resp_error_out(resp_err),
    .div_dividend_out(div_a), .div_divisor_out(div_b), .div_data_valid_out(div_start),
    .div_quotient_in(div_q), .div_remainder_in(div_r), .div_data_valid_in(div_dv),
    .div_error_in(div_err), .div_busy_in(div_busy)
  );

  always #5 clk = ~clk;

  // Divider model: result strobe arrives lat cycles after the start strobe; never reset.
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  int           m_cnt = 0;
  bit           m_pend = 1'b0;
  always @(negedge clk) begin
    #2;
    div_dv = 1'b0;
    if (m_pend) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_pend = 1'b0;
        div_dv = 1'b1;
        if (m_b == 0) begin div_q = '1; div_r = m_a; div_err = 1'b1; end
        else begin div_q = m_a / m_b; div_r = m_a % m_b; div_err = 1'b0; end
      end
    end
    if (div_start) begin m_pend = 1'b1; m_cnt = lat; m_a = div_a; m_b = div_b; end
  end

  function automatic int rr_pick(int last, logic [N-1:0] v);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic set_op(int i, logic [W-1:0] a, logic [W-1:0] b);
    req_dividend[i*W +: W] = a;
    req_divisor[i*W +: W]  = b;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_dividend = '0; req_divisor = '0; div_busy = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_ready !== '0 || resp_valid !== '0) begin errors++; $display("FAIL reset_strobes: ready=%b resp=%b want 0", req_ready, resp_valid); end
    checks++; if (div_start !== 1'b0 || resp_err !== 1'b0) begin errors++; $display("FAIL reset_flags: start=%b err=%b want 0", div_start, resp_err); end
    checks++; if (resp_q !== '0 || resp_r !== '0) begin errors++; $display("FAIL reset_resp: q=%0h r=%0h want 0", resp_q, resp_r); end
    checks++; if (div_a !== '0 || div_b !== '0) begin errors++; $display("FAIL reset_ops: a=%0h b=%0h want 0", div_a, div_b); end
    @(negedge clk);
    rst = 1'b0;
    exp_last = N - 1;
  endtask

  task automatic test_single();
    int st_at, st_n, rs_at; logic [N-1:0] rv; logic [W-1:0] q, r; logic e;
    st_at = -1; st_n = 0; rs_at = -1; rv = '0; q = '0; r = '0; e = 1'b0;
    lat = 33;
    req_valid = 4'b0100; set_op(2, 1000, 7);
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    exp_last = 2;
    @(negedge clk);
    for (int k = 1; k <= 60; k++) begin
      req_valid = '0;
      #1;
      if (div_start) begin st_n++; if (st_at < 0) st_at = k; end
      if (resp_valid !== '0 && rs_at < 0) begin rs_at = k; rv = resp_valid; q = resp_q; r = resp_r; e = resp_err; end
      @(negedge clk);
    end
    checks++; if (st_at != 1 || st_n != 1) begin errors++; $display("FAIL single_start: at=%0d count=%0d want at=1 count=1", st_at, st_n); end
    checks++; if (rs_at != 35) begin errors++; $display("FAIL single_latency: got T+%0d want T+35", rs_at); end
    checks++; if (rv !== 4'b0100) begin errors++; $display("FAIL single_route: got %b want 0100", rv); end
    checks++; if (q !== 32'd142 || r !== 32'd6 || e !== 1'b0) begin errors++; $display("FAIL single_result: q=%0d r=%0d e=%b want 142 6 0", q, r, e); end
    checks++; if (resp_q !== 32'd142 || resp_r !== 32'd6) begin errors++; $display("FAIL single_hold: q=%0d r=%0d want 142 6", resp_q, resp_r); end
  endtask

  task automatic test_all_four();
    logic [N-1:0] got, rv, oh; int wk, rk, eg; logic [W-1:0] a, b;
    rst = 1'b1; req_valid = '1; lat = 5;
    for (int i = 0; i < N; i++) set_op(i, 32'(1000 * (i + 1) + 37 * i + 13), 32'(i + 3));
    @(negedge clk);
    rst = 1'b0; exp_last = N - 1;
    for (int g = 0; g < 5; g++) begin
      eg = rr_pick(exp_last, 4'b1111); oh = N'(1) << eg; exp_last = eg;
      a = req_dividend[eg*W +: W]; b = req_divisor[eg*W +: W];
      wk = -1; got = '0;
      for (int k = 0; k < 20 && wk < 0; k++) begin
        #1;
        if (req_ready !== '0) begin wk = k; got = req_ready; end
        @(negedge clk);
      end
      checks++; if (got !== oh || wk != 0) begin errors++; $display("FAIL all4_grant%0d: got %b after %0d want %b after 0", g, got, wk, oh); end
      rk = -1; rv = '0;
      for (int k = 1; k <= 20 && rk < 0; k++) begin
        #1;
        if (resp_valid !== '0) begin rk = k; rv = resp_valid;
          checks++; if (resp_q !== a / b || resp_r !== a % b || resp_err !== 1'b0) begin errors++; $display("FAIL all4_result%0d: q=%0d r=%0d e=%b want %0d %0d 0", g, resp_q, resp_r, resp_err, a / b, a % b); end
        end
        @(negedge clk);
      end
      checks++; if (rk != lat + 2 || rv !== oh) begin errors++; $display("FAIL all4_resp%0d: at T+%0d to %b want T+%0d to %b", g, rk, rv, lat + 2, oh); end
    end
    req_valid = '0;
  endtask

  task automatic test_div_zero();
    int rk; logic [N-1:0] rv; logic e; logic [W-1:0] q, r;
    lat = 6;
    req_valid = 4'b0010; set_op(1, 55, 0);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL dz_ready: got %b want 0010", req_ready); end
    exp_last = 1;
    @(negedge clk); req_valid = '0;
    rk = -1; rv = '0; e = 1'b0;
    for (int k = 1; k <= 30 && rk < 0; k++) begin
      #1; if (resp_valid !== '0) begin rk = k; rv = resp_valid; e = resp_err; end
      @(negedge clk);
    end
    checks++; if (rv !== 4'b0010 || e !== 1'b1) begin errors++; $display("FAIL dz_error: resp=%b err=%b want 0010 1", rv, e); end
    req_valid = 4'b1000; set_op(3, 99, 10);
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL dz_next_ready: got %b want 1000", req_ready); end
    exp_last = 3;
    @(negedge clk); req_valid = '0;
    rk = -1; rv = '0; q = '0; r = '0; e = 1'b1;
    for (int k = 1; k <= 30 && rk < 0; k++) begin
      #1; if (resp_valid !== '0) begin rk = k; rv = resp_valid; q = resp_q; r = resp_r; e = resp_err; end
      @(negedge clk);
    end
    checks++; if (rv !== 4'b1000 || q !== 32'd9 || r !== 32'd9 || e !== 1'b0) begin errors++; $display("FAIL dz_next: resp=%b q=%0d r=%0d e=%b want 1000 9 9 0", rv, q, r, e); end
  endtask

  task automatic test_busy();
    int st_at, st_n, rs_at; logic [W-1:0] q, r;
    lat = 4; st_at = -1; st_n = 0; rs_at = -1; q = '0; r = '0;
    req_valid = 4'b0001; set_op(0, 12345, 67);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL busy_ready: got %b want 0001", req_ready); end
    exp_last = 0;
    @(negedge clk);
    for (int k = 1; k <= 30; k++) begin
      req_valid = '0; div_busy = (k <= 5);
      #1;
      if (div_start) begin st_n++; if (st_at < 0) st_at = k; end
      if (resp_valid !== '0 && rs_at < 0) begin rs_at = k; q = resp_q; r = resp_r; end
      @(negedge clk);
    end
    div_busy = 1'b0;
    checks++; if (st_at != 6 || st_n != 1) begin errors++; $display("FAIL busy_start: at=%0d count=%0d want at=6 count=1", st_at, st_n); end
    checks++; if (rs_at != 11) begin errors++; $display("FAIL busy_latency: got T+%0d want T+11", rs_at); end
    checks++; if (q !== 32'(12345 / 67) || r !== 32'(12345 % 67)) begin errors++; $display("FAIL busy_result: q=%0d r=%0d want %0d %0d", q, r, 12345 / 67, 12345 % 67); end
  endtask

  task automatic test_reset_mid();
    bit saw_resp; int extra; int rk; logic [N-1:0] rv, got; logic [W-1:0] q;
    saw_resp = 1'b0; extra = 0; lat = 20;
    req_valid = 4'b1000; set_op(3, 5000, 9);
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rmid_ready: got %b want 1000", req_ready); end
    @(negedge clk);
    for (int k = 1; k <= 40; k++) begin
      req_valid = '0; rst = (k == 5);
      #1;
      if (resp_valid !== '0) saw_resp = 1'b1;
      if (k > 1 && div_start) extra++;
      @(negedge clk);
    end
    checks++; if (saw_resp || extra != 0) begin errors++; $display("FAIL rmid_silent: resp=%b restarts=%0d want 0 0", saw_resp, extra); end
    #1;
    checks++; if (resp_q !== '0 || resp_r !== '0 || resp_err !== 1'b0 || div_a !== '0 || div_b !== '0) begin errors++; $display("FAIL rmid_cleared: q=%0h r=%0h e=%b a=%0h b=%0h want all 0", resp_q, resp_r, resp_err, div_a, div_b); end
    @(negedge clk);
    exp_last = N - 1;
    req_valid = 4'b0101; set_op(0, 640, 8); set_op(2, 7, 2);
    #1;
    got = req_ready;
    checks++; if (got !== (N'(1) << rr_pick(exp_last, 4'b0101))) begin errors++; $display("FAIL rmid_grant: got %b want 0001", got); end
    exp_last = 0;
    @(negedge clk); req_valid = '0;
    rk = -1; rv = '0; q = '0;
    for (int k = 1; k <= 40 && rk < 0; k++) begin
      #1; if (resp_valid !== '0) begin rk = k; rv = resp_valid; q = resp_q; end
      @(negedge clk);
    end
    checks++; if (rv !== 4'b0001 || q !== 32'd80) begin errors++; $display("FAIL rmid_next: resp=%b q=%0d want 0001 80", rv, q); end
  endtask

  task automatic test_random();
    logic [N-1:0] v, oh, rv; int eg, rk; logic [W-1:0] a, b, q, r; logic e;
    for (int it = 0; it < 20; it++) begin
      lat = $urandom_range(1, 8);
      v = N'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) set_op(i, $urandom, ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 100000)));
      eg = rr_pick(exp_last, v); oh = N'(1) << eg; exp_last = eg;
      a = req_dividend[eg*W +: W]; b = req_divisor[eg*W +: W];
      req_valid = v;
      #1;
      checks++; if (req_ready !== oh) begin errors++; $display("FAIL rand%0d_grant: got %b want %b (valid %b)", it, req_ready, oh, v); end
      @(negedge clk); req_valid = '0;
      rk = -1; rv = '0; q = '0; r = '0; e = 1'b0;
      for (int k = 1; k <= 20 && rk < 0; k++) begin
        #1; if (resp_valid !== '0) begin rk = k; rv = resp_valid; q = resp_q; r = resp_r; e = resp_err; end
        @(negedge clk);
      end
      checks++; if (rk != lat + 2 || rv !== oh) begin errors++; $display("FAIL rand%0d_resp: at T+%0d to %b want T+%0d to %b", it, rk, rv, lat + 2, oh); end
      checks++; if (e !== (b == 0)) begin errors++; $display("FAIL rand%0d_err: got %b want %b", it, e, (b == 0)); end
      if (b != 0) begin
        checks++; if (q !== a / b || r !== a % b) begin errors++; $display("FAIL rand%0d_result: q=%0d r=%0d want %0d %0d", it, q, r, a / b, a % b); end
      end
    end
  endtask

`ifdef DIV_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int rk; logic [N-1:0] rv; logic [W-1:0] q, r; logic e;
    lat = TC + 10;
    req_valid = 4'b0100; set_op(2, 77, 7);
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL to_ready: got %b want 0100", req_ready); end
    exp_last = 2;
    @(negedge clk);
    rk = -1; rv = '0; q = '1; r = '1; e = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      req_valid = '0;
      #1; if (resp_valid !== '0 && rk < 0) begin rk = k; rv = resp_valid; q = resp_q; r = resp_r; e = resp_err; end
      @(negedge clk);
    end
    checks++; if (rk != TC + 3 || rv !== 4'b0100) begin errors++; $display("FAIL to_timing: at T+%0d to %b want T+%0d to 0100", rk, rv, TC + 3); end
    checks++; if (e !== 1'b1 || q !== '0 || r !== '0) begin errors++; $display("FAIL to_result: e=%b q=%0d r=%0d want 1 0 0", e, q, r); end
    lat = 3;
    req_valid = 4'b0001; set_op(0, 81, 4);
    #1; exp_last = 0;
    @(negedge clk); req_valid = '0;
    rk = -1; rv = '0;
    for (int k = 1; k <= 20 && rk < 0; k++) begin
      #1; if (resp_valid !== '0) begin rk = k; rv = resp_valid; q = resp_q; r = resp_r; e = resp_err; end
      @(negedge clk);
    end
    checks++; if (rk != 5 || rv !== 4'b0001 || q !== 32'd20 || r !== 32'd1 || e !== 1'b0) begin errors++; $display("FAIL to_next: at T+%0d resp=%b q=%0d r=%0d e=%b want T+5 0001 20 1 0", rk, rv, q, r, e); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_div_zero();
    test_busy();
    test_reset_mid();
    test_random();
`ifdef DIV_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
